// File: rtl/rtc_timekeeper_if.sv
// Load port of the RTC timekeeper: carries a time or alarm value into the block.
// A transfer happens on a rising clock edge where set_valid and set_ready are both 1;
// the master holds set_target/set_hh/set_mm/set_ss stable while set_valid is high.
interface rtc_timekeeper_if;
    logic       set_valid;
    logic       set_ready;
    logic       set_target;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;

    modport master (
        output set_valid,
        output set_target,
        output set_hh,
        output set_mm,
        output set_ss,
        input  set_ready
    );

    modport slave (
        input  set_valid,
        input  set_target,
        input  set_hh,
        input  set_mm,
        input  set_ss,
        output set_ready
    );
endinterface

// File: rtl/rtc_timekeeper.sv
// BCD time-of-day counter driven by a sampled divider tick, with a time/alarm load
// port and one-cycle second, day-rollover, alarm and load-error pulses.
module rtc_timekeeper #(
    parameter int unsigned TICKS_PER_SEC = 4
) (
    input  logic            iclk,
    input  logic            reset,
    input  logic            tick_in,
    input  logic            run,
    input  logic            alarm_en,
    rtc_timekeeper_if.slave set_if,
    output logic [7:0]      hh,
    output logic [7:0]      mm,
    output logic [7:0]      ss,
    output logic            sec_pulse,
    output logic            day_pulse,
    output logic            alarm_hit,
    output logic            set_err,
    output logic            dbg_running,
    output logic [15:0]     dbg_pre
);
    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [15:0] PRE_MAX = 16'(TICKS_PER_SEC - 1);

    state_t      state_q;
    state_t      state_d;
    logic        tick_d;
    logic [15:0] pre;
    logic [15:0] pre_d;
    logic [7:0]  al_hh;
    logic [7:0]  al_mm;
    logic [7:0]  al_ss;
    logic        set_ready_q;

    logic        tick_rise;
    logic        counting;
    logic        sec_done;
    logic        handshake;
    logic        load_ok;
    logic        time_load;
    logic        alarm_load;
    logic        load_bad;
    logic [8:0]  ss_inc;
    logic [8:0]  mm_inc;
    logic [8:0]  hh_inc;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    // Increment a two-digit BCD field that wraps to 00 after max; bit 8 is the carry out.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return {1'b1, 8'h00};
        if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge iclk) begin
        if (reset) state_q <= STOPPED;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (run)  state_d = RUNNING;
            RUNNING: if (!run) state_d = STOPPED;
            default: state_d = STOPPED;
        endcase

        tick_rise = tick_in & ~tick_d;
        counting  = (state_q == RUNNING) && tick_rise;
        sec_done  = counting && (pre == PRE_MAX);
        pre_d     = pre;
        if (counting) pre_d = sec_done ? 16'd0 : pre + 16'd1;

        handshake  = set_if.set_valid & set_ready_q;
        load_ok    = bcd_ok(set_if.set_hh, 8'h23) && bcd_ok(set_if.set_mm, 8'h59)
                     && bcd_ok(set_if.set_ss, 8'h59);
        time_load  = handshake & load_ok & ~set_if.set_target;
        alarm_load = handshake & load_ok & set_if.set_target;
        load_bad   = handshake & ~load_ok;

        ss_inc = bcd_inc(ss, 8'h59);
        mm_inc = ss_inc[8] ? bcd_inc(mm, 8'h59) : {1'b0, mm};
        hh_inc = mm_inc[8] ? bcd_inc(hh, 8'h23) : {1'b0, hh};
    end

    always_ff @(posedge iclk) begin
        if (reset) begin
            tick_d      <= 1'b0;
            pre         <= 16'd0;
            hh          <= 8'h00;
            mm          <= 8'h00;
            ss          <= 8'h00;
            al_hh       <= 8'h00;
            al_mm       <= 8'h00;
            al_ss       <= 8'h00;
            sec_pulse   <= 1'b0;
            day_pulse   <= 1'b0;
            alarm_hit   <= 1'b0;
            set_err     <= 1'b0;
            set_ready_q <= 1'b0;
        end else begin
            tick_d      <= tick_in;
            set_ready_q <= 1'b1;
            pre         <= pre_d;
            sec_pulse   <= 1'b0;
            day_pulse   <= 1'b0;
            alarm_hit   <= 1'b0;
            set_err     <= load_bad;
            // A time load overrides a coinciding second, which is then lost silently.
            if (time_load) begin
                hh  <= set_if.set_hh;
                mm  <= set_if.set_mm;
                ss  <= set_if.set_ss;
                pre <= 16'd0;
            end else if (sec_done) begin
                hh        <= hh_inc[7:0];
                mm        <= mm_inc[7:0];
                ss        <= ss_inc[7:0];
                sec_pulse <= 1'b1;
                day_pulse <= hh_inc[8];
                alarm_hit <= alarm_en &&
                             ({hh_inc[7:0], mm_inc[7:0], ss_inc[7:0]} == {al_hh, al_mm, al_ss});
            end
            if (alarm_load) begin
                al_hh <= set_if.set_hh;
                al_mm <= set_if.set_mm;
                al_ss <= set_if.set_ss;
            end
        end
    end

    // Ready is registered, so it rises on the first edge after reset is released.
    assign set_if.set_ready = set_ready_q;
    assign dbg_running      = (state_q == RUNNING);
    assign dbg_pre          = pre;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: seconds-of-day reference model checked every cycle,
// plus directed loads, rollovers, alarm, freeze and reset scenarios.
module tb_rtc_timekeeper;
  localparam int TPS = 4;

  logic        iclk = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        run;
  logic        alarm_en;
  logic [7:0]  hh, mm, ss;
  logic        sec_pulse, day_pulse, alarm_hit, set_err;
  logic        dbg_running;
  logic [15:0] dbg_pre;

  rtc_timekeeper_if sif();

  rtc_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
    .iclk(iclk), .reset(reset), .tick_in(tick_in), .run(run), .alarm_en(alarm_en),
    .set_if(sif), .hh(hh), .mm(mm), .ss(ss), .sec_pulse(sec_pulse),
    .day_pulse(day_pulse), .alarm_hit(alarm_hit), .set_err(set_err),
    .dbg_running(dbg_running), .dbg_pre(dbg_pre)
  );

  // clock / reset
  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: time as seconds-of-day, prescaler as a plain count
  int m_sod, m_alarm, m_pre;
  bit m_run, m_tick_d, m_sec, m_day, m_hit, m_err, m_ready;
  bit chk_en = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit digits_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic bit load_legal(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return digits_ok(h) && digits_ok(m) && digits_ok(s) &&
           bcd_val(h) < 24 && bcd_val(m) < 60 && bcd_val(s) < 60;
  endfunction

  always @(posedge iclk) begin : model
    bit rise, hs, legal, sec;
    int ld;
    if (reset) begin
      m_sod = 0; m_alarm = 0; m_pre = 0; m_run = 0; m_tick_d = 0;
      m_sec = 0; m_day = 0; m_hit = 0; m_err = 0; m_ready = 0;
    end else begin
      rise  = tick_in && !m_tick_d;
      hs    = sif.set_valid && m_ready;
      legal = load_legal(sif.set_hh, sif.set_mm, sif.set_ss);
      ld    = bcd_val(sif.set_hh) * 3600 + bcd_val(sif.set_mm) * 60 + bcd_val(sif.set_ss);
      sec   = 0;
      m_sec = 0; m_day = 0; m_hit = 0;
      m_err = hs && !legal;
      if (m_run && rise) begin
        if (m_pre == TPS - 1) begin m_pre = 0; sec = 1; end
        else m_pre++;
      end
      if (hs && legal && !sif.set_target) begin
        m_sod = ld;
        m_pre = 0;
      end else if (sec) begin
        m_sod = (m_sod + 1) % 86400;
        m_sec = 1;
        m_day = (m_sod == 0);
        m_hit = alarm_en && (m_sod == m_alarm);
      end
      if (hs && legal && sif.set_target) m_alarm = ld;
      m_tick_d = tick_in;
      m_run    = run;
      m_ready  = 1;
    end
    chk_en = 1'b1;
  end

  // scoreboard compare, every cycle
  always @(negedge iclk) begin
    logic [45:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {to_bcd(m_sod / 3600), to_bcd((m_sod / 60) % 60), to_bcd(m_sod % 60),
               m_sec, m_day, m_hit, m_err, m_ready, m_run, 16'(m_pre)};
      act_v = {hh, mm, ss, sec_pulse, day_pulse, alarm_hit, set_err,
               sif.set_ready, dbg_running, dbg_pre};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model at %0t: dut %h model %h", $time, act_v, exp_v);
      end
    end
  end

  // driver tasks (all start and end on a falling edge)
  task automatic cyc(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1; cyc(12);
    tick_in = 1'b0; cyc(13);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_pulse();
  endtask

  task automatic load(input bit tgt, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    sif.set_valid = 1'b1; sif.set_target = tgt;
    sif.set_hh = h; sif.set_mm = m; sif.set_ss = s;
    cyc(1);
    sif.set_valid = 1'b0;
  endtask

  // one full second from pre == 0, checking the result on the completing rise
  task automatic sec_step(input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                          input bit eday, input bit ehit, input string tag);
    ticks(TPS - 1);
    tick_in = 1'b1; cyc(1);
    check({tag, "_hh"}, hh, eh);
    check({tag, "_mm"}, mm, em);
    check({tag, "_ss"}, ss, es);
    check({tag, "_sec_pulse"}, sec_pulse, 1);
    check({tag, "_day_pulse"}, day_pulse, eday);
    check({tag, "_alarm_hit"}, alarm_hit, ehit);
    cyc(1);
    check({tag, "_sec_pulse_gone"}, sec_pulse, 0);
    cyc(11); tick_in = 1'b0; cyc(13);
  endtask

  initial begin
    reset = 1'b1; tick_in = 1'b0; run = 1'b0; alarm_en = 1'b0;
    sif.set_valid = 1'b1; sif.set_target = 1'b0;
    sif.set_hh = 8'h12; sif.set_mm = 8'h34; sif.set_ss = 8'h56;
    cyc(3);
    check("ready_in_reset", sif.set_ready, 0);
    check("hh_in_reset", hh, 8'h00);
    reset = 1'b0; sif.set_valid = 1'b0;
    cyc(1);
    check("load_in_reset_dropped", {hh, mm, ss}, 24'h000000);
    check("ready_after_reset", sif.set_ready, 1);

    // first second with a divider-like tick
    run = 1'b1; cyc(2);
    ticks(3);
    check("pre_after_3_rises", dbg_pre, 3);
    check("ss_before_4th_rise", ss, 8'h00);
    tick_in = 1'b1; cyc(1);
    check("ss_after_4th_rise", ss, 8'h01);
    check("sec_pulse_4th_rise", sec_pulse, 1);
    check("pre_wraps", dbg_pre, 0);
    cyc(1);
    check("sec_pulse_one_cycle", sec_pulse, 0);
    cyc(11); tick_in = 1'b0; cyc(13);

    // rollovers
    load(1'b0, 8'h23, 8'h59, 8'h59);
    check("load_time_visible", {hh, mm, ss}, 24'h235959);
    sec_step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, "day_wrap");
    load(1'b0, 8'h00, 8'h59, 8'h59);
    sec_step(8'h01, 8'h00, 8'h00, 1'b0, 1'b0, "hour_wrap");
    load(1'b0, 8'h00, 8'h00, 8'h09);
    sec_step(8'h00, 8'h00, 8'h10, 1'b0, 1'b0, "digit_carry");

    // alarm enabled, then disabled
    alarm_en = 1'b1;
    load(1'b1, 8'h00, 8'h00, 8'h02);
    load(1'b0, 8'h00, 8'h00, 8'h00);
    check("time_load_no_pulse", sec_pulse, 0);
    sec_step(8'h00, 8'h00, 8'h01, 1'b0, 1'b0, "alarm_pre");
    sec_step(8'h00, 8'h00, 8'h02, 1'b0, 1'b1, "alarm_on");
    alarm_en = 1'b0;
    load(1'b0, 8'h00, 8'h00, 8'h00);
    sec_step(8'h00, 8'h00, 8'h01, 1'b0, 1'b0, "alarm_off_1");
    sec_step(8'h00, 8'h00, 8'h02, 1'b0, 1'b0, "alarm_off_2");

    // rejected loads
    load(1'b0, 8'h24, 8'h00, 8'h00);
    check("bad_hh_time_kept", {hh, mm, ss}, 24'h000002);
    check("bad_hh_err", set_err, 1);
    cyc(1);
    check("bad_hh_err_one_cycle", set_err, 0);
    load(1'b0, 8'h00, 8'h60, 8'h00);
    check("bad_mm_time_kept", {hh, mm, ss}, 24'h000002);
    check("bad_mm_err", set_err, 1);
    load(1'b0, 8'h00, 8'h00, 8'h1A);
    check("bad_ss_time_kept", {hh, mm, ss}, 24'h000002);
    check("bad_ss_err", set_err, 1);
    cyc(1);

    // load coinciding with a second-completing rise
    ticks(3);
    tick_in = 1'b1;
    sif.set_valid = 1'b1; sif.set_target = 1'b0;
    sif.set_hh = 8'h10; sif.set_mm = 8'h20; sif.set_ss = 8'h30;
    cyc(1);
    sif.set_valid = 1'b0;
    check("coincide_time", {hh, mm, ss}, 24'h102030);
    check("coincide_no_sec", sec_pulse, 0);
    check("coincide_pre", dbg_pre, 0);
    cyc(11); tick_in = 1'b0; cyc(13);

    // freeze and resume
    ticks(2);
    run = 1'b0; cyc(2);
    ticks(10);
    check("frozen_pre", dbg_pre, 2);
    check("frozen_time", {hh, mm, ss}, 24'h102030);
    check("frozen_state", dbg_running, 0);
    run = 1'b1; cyc(2);
    ticks(1);
    check("resume_pre", dbg_pre, 3);
    tick_in = 1'b1; cyc(1);
    check("resume_ss", ss, 8'h31);
    check("resume_sec", sec_pulse, 1);
    cyc(11); tick_in = 1'b0; cyc(13);

    // held-high tick gives a single rise
    tick_in = 1'b1; cyc(50);
    check("held_high_one_rise", dbg_pre, 1);
    tick_in = 1'b0; cyc(2);

    // reset mid-second
    ticks(1);
    reset = 1'b1; cyc(1);
    check("reset_mid_time", {hh, mm, ss}, 24'h000000);
    check("reset_mid_pre", dbg_pre, 0);
    check("reset_mid_pulses", {sec_pulse, day_pulse, alarm_hit, set_err, sif.set_ready}, 0);
    reset = 1'b0; cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
